// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the RV32I datapath / data memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          instr;
    logic                 Zero;
    logic                 mem_ack;
    logic                 ALUSrc;
    logic [3:0]           ALUCtrl;
    logic                 RegWrite;
    logic                 MemToReg;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 loadPC;
    logic                 PCSrc;
    logic [2:0]           state;
    logic                 retire;
    logic                 fault;
    logic [CNT_WIDTH-1:0] cycle_cnt;
    logic [CNT_WIDTH-1:0] instret_cnt;

    modport master (
        input  instr, Zero, mem_ack,
        output ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite,
               loadPC, PCSrc, state, retire, fault, cycle_cnt, instret_cnt
    );

    modport slave (
        output instr, Zero, mem_ack,
        input  ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite,
               loadPC, PCSrc, state, retire, fault, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB controller for the RV32I multicycle core with memory timeout and sticky FAULT.
// Define PERF_COUNTERS_EN to build the cycle/instret counters; otherwise both read as 0.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_RR  = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // wait_q counts completed MEM cycles, so it only needs to reach MEM_TIMEOUT-1
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [2:0]        state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       f7_zero, f7_alt, arith_ok;
    logic       is_lw, is_sw, is_beq, is_rr, is_imm, legal;
    logic [3:0] alu_op;
    logic       timeout_hit, active;
    logic       alu_src, reg_write, mem_to_reg, mem_read, mem_write, load_pc, pc_src, retire;
    logic [3:0] alu_ctrl;
    logic       unused_fields;

    assign opcode        = ir_q[6:0];
    assign funct3        = ir_q[14:12];
    assign funct7        = ir_q[31:25];
    assign unused_fields = ^{ir_q[24:15], ir_q[11:7]};

    always_comb begin
        is_lw    = (opcode == OP_LW)  && (funct3 == 3'b010);
        is_sw    = (opcode == OP_SW)  && (funct3 == 3'b010);
        is_beq   = (opcode == OP_BEQ) && (funct3 == 3'b000);
        f7_zero  = (funct7 == 7'b0000000);
        f7_alt   = (funct7 == 7'b0100000);
        arith_ok = 1'b0;
        alu_op   = ALU_ADD;
        // For IMM forms funct7 is immediate bits except on the shifts
        case (funct3)
            3'b000: begin
                alu_op   = (opcode == OP_RR && f7_alt) ? ALU_SUB : ALU_ADD;
                arith_ok = (opcode == OP_IMM) || f7_zero || f7_alt;
            end
            3'b001: begin alu_op = ALU_SLL; arith_ok = f7_zero; end
            3'b010: begin alu_op = ALU_SLT; arith_ok = (opcode == OP_IMM) || f7_zero; end
            3'b100: begin alu_op = ALU_XOR; arith_ok = (opcode == OP_IMM) || f7_zero; end
            3'b101: begin
                alu_op   = f7_alt ? ALU_SRA : ALU_SRL;
                arith_ok = f7_zero || f7_alt;
            end
            3'b110: begin alu_op = ALU_OR;  arith_ok = (opcode == OP_IMM) || f7_zero; end
            3'b111: begin alu_op = ALU_AND; arith_ok = (opcode == OP_IMM) || f7_zero; end
            default: arith_ok = 1'b0;
        endcase
        is_rr  = (opcode == OP_RR)  && arith_ok;
        is_imm = (opcode == OP_IMM) && arith_ok;
        if (is_beq) begin
            alu_op = ALU_SUB;
        end else if (is_lw || is_sw) begin
            alu_op = ALU_ADD;
        end
        legal = is_lw || is_sw || is_beq || is_rr || is_imm;
    end

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = bus.instr;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (is_beq) begin
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (timeout_hit) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    assign active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        alu_src    = active && (is_imm || is_lw || is_sw);
        alu_ctrl   = active ? alu_op : 4'b0000;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        load_pc    = 1'b0;
        pc_src     = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (is_beq) begin
                    load_pc = 1'b1;
                    pc_src  = bus.Zero;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                if (is_sw && bus.mem_ack) begin
                    load_pc = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                load_pc    = 1'b1;
                retire     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ALUSrc   = alu_src;
    assign bus.ALUCtrl  = alu_ctrl;
    assign bus.RegWrite = reg_write;
    assign bus.MemToReg = mem_to_reg;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.loadPC   = load_pc;
    assign bus.PCSrc    = pc_src;
    assign bus.state    = state_q;
    assign bus.retire   = retire;
    assign bus.fault    = (state_q == S_FAULT);

`ifdef PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cycle_q, instret_q;

    // cycle count freezes once trapped so it records time up to the fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_FAULT) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`else
    assign bus.cycle_cnt   = {CNT_WIDTH{1'b0}};
    assign bus.instret_cnt = {CNT_WIDTH{1'b0}};
`endif
endmodule
